// File: rtl/nvdla_sdp_csb_pkg.sv
// Shared CSB request/response field layout, FSM state type and pack/unpack
// helpers for the SDP CSB initiator.
package nvdla_sdp_csb_pkg;

    localparam int unsigned CSB_ADDR_W  = 22;
    localparam int unsigned CSB_DATA_W  = 32;
    localparam int unsigned CSB_REQ_W   = 63;
    localparam int unsigned CSB_RESP_W  = 34;
    localparam int unsigned CNT_W       = 16;

    localparam int unsigned REQ_ADDR_LSB    = 0;
    localparam int unsigned REQ_WDAT_LSB    = 22;
    localparam int unsigned REQ_WRITE_BIT   = 54;
    localparam int unsigned REQ_NPOSTED_BIT = 55;
    localparam int unsigned REQ_SRCPRIV_BIT = 56;
    localparam int unsigned REQ_WRBE_LSB    = 57;
    localparam int unsigned REQ_WRBE_W      = 4;
    localparam int unsigned REQ_LEVEL_LSB   = 61;
    localparam int unsigned REQ_LEVEL_W     = 2;

    localparam int unsigned RESP_RDAT_LSB  = 0;
    localparam int unsigned RESP_ERROR_BIT = 32;
    localparam int unsigned RESP_TYPE_BIT  = 33;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    typedef struct packed {
        logic                  rtype;
        logic                  error;
        logic [CSB_DATA_W-1:0] rdat;
    } csb_resp_t;

    // Reads carry no data and are never non-posted.
    function automatic logic [CSB_REQ_W-1:0] pack_req(
        input logic [CSB_ADDR_W-1:0] addr,
        input logic [CSB_DATA_W-1:0] wdat,
        input logic                  write,
        input logic                  nposted
    );
        logic [CSB_REQ_W-1:0] pd;
        pd = '0;
        pd[REQ_ADDR_LSB +: CSB_ADDR_W]  = addr;
        pd[REQ_WDAT_LSB +: CSB_DATA_W]  = write ? wdat : '0;
        pd[REQ_WRITE_BIT]               = write;
        pd[REQ_NPOSTED_BIT]             = write & nposted;
        pd[REQ_SRCPRIV_BIT]             = 1'b0;
        pd[REQ_WRBE_LSB +: REQ_WRBE_W]  = '1;
        pd[REQ_LEVEL_LSB +: REQ_LEVEL_W] = '0;
        return pd;
    endfunction

    function automatic csb_resp_t unpack_resp(input logic [CSB_RESP_W-1:0] pd);
        csb_resp_t r;
        r.rdat  = pd[RESP_RDAT_LSB +: CSB_DATA_W];
        r.error = pd[RESP_ERROR_BIT];
        r.rtype = pd[RESP_TYPE_BIT];
        return r;
    endfunction

endpackage

// File: rtl/nvdla_sdp_csb_initiator_if.sv
// Command, CSB and result handshake bundle of the SDP CSB initiator.
interface nvdla_sdp_csb_initiator_if;
    import nvdla_sdp_csb_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [CSB_ADDR_W-1:0] cmd_addr;
    logic [CSB_DATA_W-1:0] cmd_wdat;
    logic                  cmd_write;
    logic                  cmd_nposted;

    logic                  csb_req_pvld;
    logic                  csb_req_prdy;
    logic [CSB_REQ_W-1:0]  csb_req_pd;
    logic                  csb_resp_valid;
    logic [CSB_RESP_W-1:0] csb_resp_pd;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [CSB_DATA_W-1:0] rsp_rdat;
    logic                  rsp_error;
    logic                  rsp_timeout;

    logic                  busy;
    logic                  stray_resp;

    modport master (
        input  cmd_valid, cmd_addr, cmd_wdat, cmd_write, cmd_nposted,
        input  csb_req_prdy, csb_resp_valid, csb_resp_pd, rsp_ready,
        output cmd_ready, csb_req_pvld, csb_req_pd,
        output rsp_valid, rsp_rdat, rsp_error, rsp_timeout, busy, stray_resp
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_wdat, cmd_write, cmd_nposted,
        output csb_req_prdy, csb_resp_valid, csb_resp_pd, rsp_ready,
        input  cmd_ready, csb_req_pvld, csb_req_pd,
        input  rsp_valid, rsp_rdat, rsp_error, rsp_timeout, busy, stray_resp
    );
endinterface

// File: rtl/nvdla_sdp_csb_initiator.sv
// Single-outstanding CSB initiator for the SDP register port: packs a local
// command into a CSB request, waits (with timeout) for the response, returns it.
module nvdla_sdp_csb_initiator
    import nvdla_sdp_csb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                              nvdla_core_clk,
    input  logic                              nvdla_core_rstn,
    nvdla_sdp_csb_initiator_if.master         bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [CSB_REQ_W-1:0]  req_pd, req_pd_n;
    logic [CSB_DATA_W-1:0] rdat, rdat_n;
    logic                  error, error_n;
    logic                  timeout, timeout_n;
    logic                  cmd_ready, req_pvld, rsp_valid, busy, stray;
    logic                  req_write, req_nposted;
    csb_resp_t             resp;

    assign resp        = unpack_resp(bus.csb_resp_pd);
    assign req_write   = req_pd[REQ_WRITE_BIT];
    assign req_nposted = req_pd[REQ_NPOSTED_BIT];

    // Next-state and next-result logic.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        req_pd_n  = req_pd;
        rdat_n    = rdat;
        error_n   = error;
        timeout_n = timeout;
        unique case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    req_pd_n = pack_req(bus.cmd_addr, bus.cmd_wdat,
                                        bus.cmd_write, bus.cmd_nposted);
                    state_n  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.csb_req_prdy) begin
                    if (!req_write || req_nposted) begin
                        cnt_n   = '0;
                        state_n = ST_WAIT;
                    end else begin
                        rdat_n    = '0;
                        error_n   = 1'b0;
                        timeout_n = 1'b0;
                        state_n   = ST_RSP;
                    end
                end
            end
            ST_WAIT: begin
                // A response in the final counted cycle still beats the timeout.
                if (bus.csb_resp_valid) begin
                    rdat_n    = req_write ? '0 : resp.rdat;
                    error_n   = resp.error | (resp.rtype != req_write);
                    timeout_n = 1'b0;
                    state_n   = ST_RSP;
                end else if (cnt == CNT_LAST) begin
                    rdat_n    = '0;
                    error_n   = 1'b0;
                    timeout_n = 1'b1;
                    state_n   = ST_RSP;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_RSP: begin
                if (bus.rsp_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req_pd    <= '0;
            rdat      <= '0;
            error     <= 1'b0;
            timeout   <= 1'b0;
            cmd_ready <= 1'b0;
            req_pvld  <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            stray     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            req_pd    <= req_pd_n;
            rdat      <= rdat_n;
            error     <= error_n;
            timeout   <= timeout_n;
            cmd_ready <= (state_n == ST_IDLE);
            req_pvld  <= (state_n == ST_REQ);
            rsp_valid <= (state_n == ST_RSP);
            busy      <= (state_n != ST_IDLE);
            stray     <= bus.csb_resp_valid && (state != ST_WAIT);
        end
    end

    assign bus.cmd_ready    = cmd_ready;
    assign bus.csb_req_pvld = req_pvld;
    assign bus.csb_req_pd   = req_pd;
    assign bus.rsp_valid    = rsp_valid;
    assign bus.rsp_rdat     = rdat;
    assign bus.rsp_error    = error;
    assign bus.rsp_timeout  = timeout;
    assign bus.busy         = busy;
    assign bus.stray_resp   = stray;

endmodule

// File: tb/tb_nvdla_sdp_csb_initiator.sv
// Table-driven bench for the SDP CSB initiator with a result scoreboard and
// hand-written stray-response and mid-transaction reset sequences.
module tb_nvdla_sdp_csb_initiator;

    localparam int unsigned TO = 8;

    logic nvdla_core_clk;
    logic nvdla_core_rstn;

    nvdla_sdp_csb_initiator_if bus();

    nvdla_sdp_csb_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rstn(nvdla_core_rstn),
        .bus            (bus)
    );

    initial nvdla_core_clk = 1'b0;
    always #5 nvdla_core_clk = ~nvdla_core_clk;

    typedef struct {
        logic        write;
        logic        nposted;
        logic [21:0] addr;
        logic [31:0] wdat;
        int          prdy_dly;
        int          resp_dly;   // -1: slave never answers
        logic [33:0] resp_pd;
        int          hold;
        logic [31:0] exp_rdat;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdat;
        logic        err;
        logic        to;
    } res_t;

    vec_t vecs[10];
    res_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic step();
        @(posedge nvdla_core_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [62:0] exp_req(input logic [21:0] a, input logic [31:0] d,
                                            input logic w, input logic np);
        logic [31:0] dd;
        dd = w ? d : 32'h0;
        return {2'b00, 4'hF, 1'b0, (w & np), w, dd, a};
    endfunction

    task automatic run_txn(input vec_t v);
        res_t        exp, got;
        logic [62:0] epd;
        int          n, exp_n;
        bit          needs_resp;
        epd        = exp_req(v.addr, v.wdat, v.write, v.nposted);
        needs_resp = !v.write || v.nposted;
        exp_n      = (needs_resp && v.resp_dly < 0) ? int'(TO) : 0;
        sb.push_back('{v.exp_rdat, v.exp_err, v.exp_to});

        bus.cmd_addr    = v.addr;
        bus.cmd_wdat    = v.wdat;
        bus.cmd_write   = v.write;
        bus.cmd_nposted = v.nposted;
        bus.cmd_valid   = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin step(); n++; end
        check("cmd_ready_idle", bus.cmd_ready, 1);
        step();
        bus.cmd_valid = 1'b0;
        check("req_after_accept", {bus.csb_req_pvld, bus.busy, bus.cmd_ready}, 3'b110);
        check("req_pd", bus.csb_req_pd, epd);

        for (int i = 0; i < v.prdy_dly; i++) begin
            step();
            check("req_held", {bus.csb_req_pvld, bus.csb_req_pd}, {1'b1, epd});
        end
        bus.csb_req_prdy = 1'b1;
        step();
        bus.csb_req_prdy = 1'b0;

        if (needs_resp && v.resp_dly >= 0) begin
            for (int i = 0; i < v.resp_dly; i++) step();
            bus.csb_resp_pd    = v.resp_pd;
            bus.csb_resp_valid = 1'b1;
            step();
            bus.csb_resp_valid = 1'b0;
        end

        n = 0;
        while (!bus.rsp_valid && n < 40) begin step(); n++; end
        check("rsp_latency", n, exp_n);
        check("rsp_valid", bus.rsp_valid, 1);
        got = '{bus.rsp_rdat, bus.rsp_error, bus.rsp_timeout};
        if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
        end else begin
            exp = sb.pop_front();
            check("rsp_result", got, exp);
            for (int i = 0; i < v.hold; i++) begin
                step();
                check("rsp_stall", {bus.rsp_valid, bus.rsp_rdat, bus.rsp_error,
                                    bus.rsp_timeout, bus.cmd_ready},
                      {1'b1, exp, 1'b0});
            end
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("idle_after_rsp", {bus.cmd_ready, bus.rsp_valid, bus.busy}, 3'b100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vecs[0] = '{0, 1, 22'h00B004, 32'h00000055, 2, 0, {2'b00, 32'hDEADBEEF}, 0, 32'hDEADBEEF, 0, 0};
        vecs[1] = '{1, 0, 22'h00B010, 32'h12345678, 0, -1, 34'h0, 0, 32'h0, 0, 0};
        vecs[2] = '{1, 1, 22'h00B014, 32'hAAAA5555, 1, 3, {2'b11, 32'h0}, 0, 32'h0, 1, 0};
        vecs[3] = '{1, 1, 22'h00B018, 32'h00000001, 0, 0, {2'b00, 32'h1234}, 0, 32'h0, 1, 0};
        vecs[4] = '{0, 0, 22'h00B01C, 32'h0, 0, 2, {2'b01, 32'hCAFEF00D}, 0, 32'hCAFEF00D, 1, 0};
        vecs[5] = '{0, 0, 22'h00B020, 32'h0, 3, 1, {2'b10, 32'h11112222}, 0, 32'h11112222, 1, 0};
        vecs[6] = '{0, 0, 22'h3FFFFF, 32'h0, 0, 7, {2'b00, 32'h0BADF00D}, 0, 32'h0BADF00D, 0, 0};
        vecs[7] = '{0, 0, 22'h00B024, 32'h0, 0, -1, 34'h0, 0, 32'h0, 0, 1};
        vecs[8] = '{1, 1, 22'h00B028, 32'hFFFFFFFF, 0, 1, {2'b10, 32'hFFFFFFFF}, 0, 32'h0, 0, 0};
        vecs[9] = '{0, 0, 22'h00B02C, 32'h0, 0, 0, {2'b00, 32'hA5A5A5A5}, 10, 32'hA5A5A5A5, 0, 0};

        nvdla_core_rstn    = 1'b0;
        bus.cmd_valid      = 1'b0;
        bus.cmd_addr       = '0;
        bus.cmd_wdat       = '0;
        bus.cmd_write      = 1'b0;
        bus.cmd_nposted    = 1'b0;
        bus.csb_req_prdy   = 1'b0;
        bus.csb_resp_valid = 1'b0;
        bus.csb_resp_pd    = '0;
        bus.rsp_ready      = 1'b0;
        step();
        step();
        check("reset_outputs", {bus.cmd_ready, bus.csb_req_pvld, bus.csb_req_pd, bus.rsp_valid,
                                bus.rsp_rdat, bus.rsp_error, bus.rsp_timeout, bus.busy,
                                bus.stray_resp}, '0);
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b1;
        step();
        check("ready_after_reset", {bus.cmd_ready, bus.busy}, 2'b10);

        for (int i = 0; i < 10; i++) run_txn(vecs[i]);

        // Late response after a timeout is stray and produces no second result.
        run_txn(vecs[7]);
        bus.csb_resp_pd    = {2'b00, 32'h5555AAAA};
        bus.csb_resp_valid = 1'b1;
        step();
        bus.csb_resp_valid = 1'b0;
        check("stray_pulse", {bus.stray_resp, bus.rsp_valid, bus.cmd_ready}, 3'b101);
        step();
        check("stray_one_cycle", {bus.stray_resp, bus.rsp_valid}, 2'b00);

        // Reset while waiting for a response abandons the transaction.
        bus.cmd_addr    = 22'h00B030;
        bus.cmd_write   = 1'b0;
        bus.cmd_nposted = 1'b0;
        bus.cmd_valid   = 1'b1;
        step();
        bus.cmd_valid    = 1'b0;
        bus.csb_req_prdy = 1'b1;
        step();
        bus.csb_req_prdy = 1'b0;
        step();
        check("in_wait_busy", {bus.busy, bus.csb_req_pvld, bus.rsp_valid}, 3'b100);
        nvdla_core_rstn = 1'b0;
        #1;
        check("async_reset", {bus.cmd_ready, bus.csb_req_pvld, bus.csb_req_pd, bus.rsp_valid,
                              bus.rsp_rdat, bus.rsp_error, bus.rsp_timeout, bus.busy,
                              bus.stray_resp}, '0);
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b1;
        step();
        check("idle_after_reset", {bus.cmd_ready, bus.busy}, 2'b10);
        for (int i = 0; i < 12; i++) begin
            step();
            check("no_ghost_txn", {bus.csb_req_pvld, bus.rsp_valid, bus.cmd_ready}, 3'b001);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/nvdla_sdp_csb_initiator.md
# nvdla_sdp_csb_initiator

CSB initiator that drives the SDP register slave port (`csb2sdp_req_*` / `sdp2csb_resp_*`, and equally the SDP RDMA port). It accepts one register command at a time from a local command interface and packs it into the 63-bit CSB request. For reads and non-posted writes it waits for the 34-bit response, with a timeout, and returns the result on a ready/valid response interface. It is used by the SDP standalone bring-up bench and by the config sequencer that programs SDP without the full CSB fabric.

## Interface
- `TIMEOUT_CYCLES`, 1023: number of WAIT cycles before a missing response is declared timed out (range 1..65535).
- `nvdla_core_clk`  in  1: the single clock.
- `nvdla_core_rstn`  in  1: asynchronous, active-low reset.
- `cmd_valid`  in  1: command offered.
- `cmd_ready`  out  1: command accepted when high together with `cmd_valid`.
- `cmd_addr`  in  22: CSB word address.
- `cmd_wdat`  in  32: write data.
- `cmd_write`  in  1: 1 = write, 0 = read.
- `cmd_nposted`  in  1: write needs an acknowledge; ignored for reads.
- `csb_req_pvld`  out  1: CSB request valid.
- `csb_req_prdy`  in  1: CSB request ready.
- `csb_req_pd`  out  63: CSB request packet.
- `csb_resp_valid`  in  1: CSB response valid. Valid-only; there is no backpressure on this port.
- `csb_resp_pd`  in  34: CSB response packet.
- `rsp_valid`  out  1: result valid.
- `rsp_ready`  in  1: result accepted.
- `rsp_rdat`  out  32: read data; 0 for writes.
- `rsp_error`  out  1: slave error bit, or response type mismatch.
- `rsp_timeout`  out  1: no response arrived within `TIMEOUT_CYCLES`.
- `busy`  out  1: state is not IDLE.
- `stray_resp`  out  1: one-cycle pulse when a response arrives outside WAIT.

## Operation
- **Request packing:**
  - `[21:0]` addr
  - `[53:22]` wdat (forced to 0 for reads)
  - `[54]` write
  - `[55]` nposted (forced to 0 for reads)
  - `[56]` srcpriv = 0
  - `[60:57]` wrbe = 4'hF
  - `[62:61]` level = 0
- **Response unpacking:** `[31:0]` rdat, `[32]` error, `[33]` type (1 = write ack, 0 = read data).
- **State machine:** IDLE, REQ, WAIT, RSP.
  - IDLE: `cmd_ready` = 1. When `cmd_valid` is high, latch the command and go to REQ.
  - REQ: `csb_req_pvld` = 1 and `csb_req_pd` are held stable until `csb_req_prdy`. On the handshake:
    - read or non-posted write: go to WAIT and clear the timeout counter;
    - posted write: go to RSP with rdat = 0, error = 0, timeout = 0.
  - WAIT: the counter increments every cycle.
    - On `csb_resp_valid`, capture rdat (writes report 0), set error = `pd[32]` OR (`pd[33]` != latched write), and go to RSP.
    - When the counter reaches `TIMEOUT_CYCLES - 1` with no response, go to RSP with timeout = 1, error = 0, rdat = 0.
  - RSP: `rsp_valid` = 1 with the result held stable until `rsp_ready`, then return to IDLE.
- One transaction outstanding at most. `cmd_ready` is low in every state except IDLE.
- **Stray responses:** a `csb_resp_valid` in IDLE, REQ or RSP is discarded and pulses `stray_resp` one cycle later. A response arriving after a timeout is therefore stray.
- **Counter:** 16 bits, saturating.

## Timing
- **Reset values:** all outputs 0, `csb_req_pd` = 0, state IDLE, counter 0. Reset mid-transaction abandons the transaction; no request or result is emitted afterwards.
- **Request latency:** command accepted in cycle T gives `csb_req_pvld` in cycle T+1 (registered).
- **Response latency:** response in cycle N (in WAIT) gives `rsp_valid` in cycle N+1. A posted-write handshake in cycle H gives `rsp_valid` in H+1.
- **Response vs timeout in the same cycle:** the response wins; timeout = 0.
- **Back-to-back commands:** after `rsp_ready` in cycle R, `cmd_ready` is high in R+1. The minimum issue interval is 3 cycles for posted writes.
- **Registered outputs:** all outputs are registered; none combinationally depends on an input.

## Structure
- **Package `nvdla_sdp_csb_pkg`:**
  - CSB request field offsets and widths;
  - CSB response field offsets;
  - the state enum;
  - pack/unpack functions.
- **No sub-module:** a single flat FSM plus counter. The expected size is about 150–200 lines.

## Test plan
- **Read:** cmd addr=0x00B004, write=0. Slave takes `prdy` after 2 cycles, then responds `pd` = {1'b0, 1'b0, 32'hDEADBEEF}. Expect `csb_req_pd[21:0]` = 0x00B004 and `[54]` = 0, `rsp_rdat` = 0xDEADBEEF, no error or timeout.
- **Posted write:** addr=0x00B010, wdat=0x12345678, nposted=0. Expect `pd[53:22]` = 0x12345678, `[54]` = 1, `[60:57]` = 4'hF, and `rsp_valid` one cycle after the handshake with no response needed.
- **Non-posted write with errored ack:** the slave returns `pd[33]` = 1, `pd[32]` = 1. Expect `rsp_error` = 1. A second run returns `pd[33]` = 0 (type mismatch) and also expects `rsp_error` = 1.
- **Timeout:** `TIMEOUT_CYCLES` = 8, read, no response.
  - Expect `rsp_timeout` = 1 exactly 8 WAIT cycles after the handshake.
  - A late response then produces a `stray_resp` pulse and no second `rsp_valid`.
- **Backpressure and reset:**
  - Hold `rsp_ready` = 0 for 10 cycles: the result is stable and `cmd_ready` = 0.
  - Assert `nvdla_core_rstn` low while in WAIT: all outputs go to 0 immediately, and after release the block is in IDLE with `cmd_ready` = 1 next cycle.
